// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_D  = 1'b1
  } grant_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: when both request, the one not granted last wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic       req_if,
  input  logic       req_d,
  input  grant_e     last_grant,
  output logic [1:0] grant
);

  // grant[0] = fetch port, grant[1] = data port
  always_comb begin
    grant = 2'b00;
    if (req_if && req_d) begin
      grant = (last_grant == GRANT_IF) ? 2'b10 : 2'b01;
    end else if (req_if) begin
      grant = 2'b01;
    end else if (req_d) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between the fetch and data ports,
// one transaction in flight, round-robin between the two requesters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_we,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  grant_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [31:0]       if_rsp_data_q, if_rsp_data_d;
  logic [31:0]       d_rsp_data_q, d_rsp_data_d;
  logic [1:0]        grant;
  logic [31:0]       rsp_word;

  rr_arbiter2 u_rr (
    .req_if     (if_req_valid),
    .req_d      (d_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Stores complete with a zero response word.
  assign rsp_word = (we_q != 4'b0000) ? 32'h0 : mem_rdata;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    we_d           = we_q;
    mem_en_d       = 1'b0;
    mem_we_d       = 4'b0000;
    if_rsp_valid_d = 1'b0;
    d_rsp_valid_d  = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    d_rsp_data_d   = d_rsp_data_q;
    if_req_ready   = 1'b0;
    d_req_ready    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if_req_ready = grant[0];
        d_req_ready  = grant[1];
        if (grant[0]) begin
          owner_d      = GRANT_IF;
          last_grant_d = GRANT_IF;
          addr_d       = if_addr;
          wdata_d      = 32'h0;
          we_d         = 4'b0000;
          mem_en_d     = 1'b1;
          state_d      = ARB_ISSUE;
        end else if (grant[1]) begin
          owner_d      = GRANT_D;
          last_grant_d = GRANT_D;
          addr_d       = d_addr;
          wdata_d      = d_wdata;
          we_d         = d_we;
          mem_en_d     = 1'b1;
          mem_we_d     = d_we;
          state_d      = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ARB_RESP;
          if (owner_q == GRANT_IF) begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = rsp_word;
          end else begin
            d_rsp_valid_d = 1'b1;
            d_rsp_data_d  = rsp_word;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ARB_IDLE;
      last_grant_q   <= GRANT_D;
      owner_q        <= GRANT_IF;
      cnt_q          <= '0;
      addr_q         <= 32'h0;
      wdata_q        <= 32'h0;
      we_q           <= 4'b0000;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 4'b0000;
      if_rsp_valid_q <= 1'b0;
      d_rsp_valid_q  <= 1'b0;
      if_rsp_data_q  <= 32'h0;
      d_rsp_data_q   <= 32'h0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      we_q           <= we_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      d_rsp_valid_q  <= d_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      d_rsp_data_q   <= d_rsp_data_d;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_we       = mem_we_q;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign d_rsp_valid  = d_rsp_valid_q;
  assign d_rsp_data   = d_rsp_data_q;
  assign busy         = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table on a
// MEM_LATENCY=1 instance plus hand sequences on a MEM_LATENCY=4 instance.
module tb_mem_port_arbiter;

  typedef struct {
    logic        rst;
    logic        if_v;
    logic [31:0] if_a;
    logic        d_v;
    logic [31:0] d_a;
    logic [31:0] d_wd;
    logic [3:0]  d_we;
    logic [31:0] rdata;
    logic        e_if_rdy;
    logic        e_d_rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic        chk_wd;
    logic [31:0] e_wd;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
    logic        e_busy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        d_req_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_we;
  logic [31:0] mem_rdata;

  logic        o1_if_ready, o1_d_ready, o1_if_rv, o1_d_rv, o1_en, o1_busy;
  logic [31:0] o1_if_rd, o1_d_rd, o1_addr, o1_wdata;
  logic [3:0]  o1_we;
  logic        o4_if_ready, o4_d_ready, o4_if_rv, o4_d_rv, o4_en, o4_busy;
  logic [31:0] o4_if_rd, o4_d_rd, o4_addr, o4_wdata;
  logic [3:0]  o4_we;

  int errors = 0;
  int checks = 0;
  vec_t vecs[15];

  mem_port_arbiter #(.MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(o1_if_ready), .if_addr(if_addr),
    .if_rsp_valid(o1_if_rv), .if_rsp_data(o1_if_rd),
    .d_req_valid(d_req_valid), .d_req_ready(o1_d_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we),
    .d_rsp_valid(o1_d_rv), .d_rsp_data(o1_d_rd),
    .mem_en(o1_en), .mem_addr(o1_addr), .mem_wdata(o1_wdata), .mem_we(o1_we),
    .mem_rdata(mem_rdata), .busy(o1_busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(o4_if_ready), .if_addr(if_addr),
    .if_rsp_valid(o4_if_rv), .if_rsp_data(o4_if_rd),
    .d_req_valid(d_req_valid), .d_req_ready(o4_d_ready), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_we(d_we),
    .d_rsp_valid(o4_d_rv), .d_rsp_data(o4_d_rd),
    .mem_en(o4_en), .mem_addr(o4_addr), .mem_wdata(o4_wdata), .mem_we(o4_we),
    .mem_rdata(mem_rdata), .busy(o4_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    if_req_valid = v.if_v;
    if_addr      = v.if_a;
    d_req_valid  = v.d_v;
    d_addr       = v.d_a;
    d_wdata      = v.d_wd;
    d_we         = v.d_we;
    mem_rdata    = v.rdata;
  endtask

  task automatic checkVector(input vec_t v, input int i);
    checkOutput($sformatf("v%0d.if_ready", i), 32'(o1_if_ready), 32'(v.e_if_rdy));
    checkOutput($sformatf("v%0d.d_ready", i),  32'(o1_d_ready),  32'(v.e_d_rdy));
    checkOutput($sformatf("v%0d.mem_en", i),   32'(o1_en),       32'(v.e_en));
    checkOutput($sformatf("v%0d.mem_addr", i), o1_addr,          v.e_addr);
    checkOutput($sformatf("v%0d.mem_we", i),   32'(o1_we),       32'(v.e_we));
    if (v.chk_wd) checkOutput($sformatf("v%0d.mem_wdata", i), o1_wdata, v.e_wd);
    checkOutput($sformatf("v%0d.if_rsp_valid", i), 32'(o1_if_rv), 32'(v.e_if_rv));
    checkOutput($sformatf("v%0d.if_rsp_data", i),  o1_if_rd,      v.e_if_rd);
    checkOutput($sformatf("v%0d.d_rsp_valid", i),  32'(o1_d_rv),  32'(v.e_d_rv));
    checkOutput($sformatf("v%0d.d_rsp_data", i),   o1_d_rd,       v.e_d_rd);
    checkOutput($sformatf("v%0d.busy", i),         32'(o1_busy),  32'(v.e_busy));
  endtask

  task automatic clearInputs();
    if_req_valid = 1'b0;
    if_addr      = 32'h0;
    d_req_valid  = 1'b0;
    d_addr       = 32'h0;
    d_wdata      = 32'h0;
    d_we         = 4'b0000;
    mem_rdata    = 32'h0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clearInputs();

    // rst if_v if_a d_v d_a d_wd d_we rdata | if_rdy d_rdy en addr we chk_wd wd if_rv if_rd d_rv d_rd busy
    vecs[0]  = '{0,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,0,32'h0,   4'h0,1,32'h0,       0,32'h0,       0,32'h0,0};
    vecs[1]  = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,0,32'h0,   4'h0,1,32'h0,       0,32'h0,       0,32'h0,0};
    vecs[2]  = '{1,1,32'h100,0,32'h0,   32'h0,       4'h0,32'h0,        1,0,0,32'h0,   4'h0,0,32'h0,       0,32'h0,       0,32'h0,0};
    vecs[3]  = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,1,32'h100, 4'h0,0,32'h0,       0,32'h0,       0,32'h0,1};
    vecs[4]  = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h00500093, 0,0,0,32'h100, 4'h0,0,32'h0,       0,32'h0,       0,32'h0,1};
    vecs[5]  = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,0,32'h100, 4'h0,0,32'h0,       1,32'h00500093,0,32'h0,1};
    vecs[6]  = '{1,0,32'h0,  1,32'h2004,32'hDEADBEEF,4'h3,32'h0,        0,1,0,32'h100, 4'h0,0,32'h0,       0,32'h00500093,0,32'h0,0};
    vecs[7]  = '{1,1,32'h300,0,32'h0,   32'h0,       4'h0,32'h11111111, 0,0,1,32'h2004,4'h3,1,32'hDEADBEEF,0,32'h00500093,0,32'h0,1};
    vecs[8]  = '{1,1,32'h300,0,32'h0,   32'h0,       4'h0,32'h12345678, 0,0,0,32'h2004,4'h0,1,32'hDEADBEEF,0,32'h00500093,0,32'h0,1};
    vecs[9]  = '{1,1,32'h300,0,32'h0,   32'h0,       4'h0,32'h0,        0,0,0,32'h2004,4'h0,0,32'h0,       0,32'h00500093,1,32'h0,1};
    vecs[10] = '{1,1,32'h300,0,32'h0,   32'h0,       4'h0,32'h0,        1,0,0,32'h2004,4'h0,0,32'h0,       0,32'h00500093,0,32'h0,0};
    vecs[11] = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,1,32'h300, 4'h0,0,32'h0,       0,32'h00500093,0,32'h0,1};
    vecs[12] = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h00A00113, 0,0,0,32'h300, 4'h0,0,32'h0,       0,32'h00500093,0,32'h0,1};
    vecs[13] = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,0,32'h300, 4'h0,0,32'h0,       1,32'h00A00113,0,32'h0,1};
    vecs[14] = '{1,0,32'h0,  0,32'h0,   32'h0,       4'h0,32'h0,        0,0,0,32'h300, 4'h0,0,32'h0,       0,32'h00A00113,0,32'h0,0};

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkVector(vecs[i], i);
    end

    // Contention on the latency-1 instance: accepts every 4 cycles, IF first.
    doReset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if_req_valid = 1'b1;
      if_addr      = 32'h1000;
      d_req_valid  = 1'b1;
      d_addr       = 32'h2000;
      d_we         = 4'b0000;
      mem_rdata    = 32'h0;
      #1;
      checkOutput($sformatf("cont%0d.both_ready", c), 32'(o1_if_ready & o1_d_ready), 32'h0);
      checkOutput($sformatf("cont%0d.if_ready", c), 32'(o1_if_ready),
                  32'((c % 4 == 0) && ((c / 4) % 2 == 0)));
      checkOutput($sformatf("cont%0d.d_ready", c), 32'(o1_d_ready),
                  32'((c % 4 == 0) && ((c / 4) % 2 == 1)));
      checkOutput($sformatf("cont%0d.if_rsp_valid", c), 32'(o1_if_rv),
                  32'((c % 4 == 3) && ((c / 4) % 2 == 0)));
      checkOutput($sformatf("cont%0d.d_rsp_valid", c), 32'(o1_d_rv),
                  32'((c % 4 == 3) && ((c / 4) % 2 == 1)));
    end

    // Latency-4 load: only the word presented in cycle 5 may be captured.
    doReset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      clearInputs();
      if (c == 0) begin
        d_req_valid = 1'b1;
        d_addr      = 32'h40;
      end
      if (c >= 2 && c <= 4) mem_rdata = 32'hBAD00000 + 32'(c);
      if (c == 5) mem_rdata = 32'hCAFEF00D;
      if (c == 6) mem_rdata = 32'hBADBAD00;
      #1;
      if (c == 0) checkOutput("ld4.d_ready", 32'(o4_d_ready), 32'h1);
      if (c == 1) begin
        checkOutput("ld4.issue_en", 32'(o4_en), 32'h1);
        checkOutput("ld4.issue_addr", o4_addr, 32'h40);
        checkOutput("ld4.issue_we", 32'(o4_we), 32'h0);
      end
      if (c >= 2 && c <= 5) begin
        checkOutput($sformatf("ld4.c%0d.mem_en", c), 32'(o4_en), 32'h0);
        checkOutput($sformatf("ld4.c%0d.d_rsp_valid", c), 32'(o4_d_rv), 32'h0);
      end
      if (c == 6) begin
        checkOutput("ld4.d_rsp_valid", 32'(o4_d_rv), 32'h1);
        checkOutput("ld4.d_rsp_data", o4_d_rd, 32'hCAFEF00D);
        checkOutput("ld4.if_rsp_valid", 32'(o4_if_rv), 32'h0);
      end
      if (c == 7) begin
        checkOutput("ld4.busy_after", 32'(o4_busy), 32'h0);
        checkOutput("ld4.d_rsp_hold", o4_d_rd, 32'hCAFEF00D);
      end
    end

    // Reset during WAIT: the fetch is abandoned and round-robin state restarts.
    doReset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      clearInputs();
      rst = (c == 3) ? 1'b0 : 1'b1;
      if (c == 0) begin
        if_req_valid = 1'b1;
        if_addr      = 32'h500;
      end
      if (c == 12) begin
        if_req_valid = 1'b1;
        if_addr      = 32'h600;
        d_req_valid  = 1'b1;
        d_addr       = 32'h700;
      end
      mem_rdata = 32'h5A5A5A5A;
      #1;
      if (c == 0) checkOutput("rst4.if_ready", 32'(o4_if_ready), 32'h1);
      if (c == 1) checkOutput("rst4.issue_en", 32'(o4_en), 32'h1);
      if (c == 2) checkOutput("rst4.busy_wait", 32'(o4_busy), 32'h1);
      if (c == 4) begin
        checkOutput("rst4.busy", 32'(o4_busy), 32'h0);
        checkOutput("rst4.mem_en", 32'(o4_en), 32'h0);
        checkOutput("rst4.mem_addr", o4_addr, 32'h0);
        checkOutput("rst4.mem_we", 32'(o4_we), 32'h0);
        checkOutput("rst4.mem_wdata", o4_wdata, 32'h0);
      end
      if (c >= 4 && c <= 11) begin
        checkOutput($sformatf("rst4.c%0d.if_rsp_valid", c), 32'(o4_if_rv), 32'h0);
        checkOutput($sformatf("rst4.c%0d.d_rsp_valid", c), 32'(o4_d_rv), 32'h0);
      end
      if (c == 12) begin
        checkOutput("rst4.regrant_if", 32'(o4_if_ready), 32'h1);
        checkOutput("rst4.regrant_d", 32'(o4_d_ready), 32'h0);
      end
    end

    @(negedge clk);
    clearInputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the single-cycle core's instruction-fetch port and data port.
- Uses a valid/ready request handshake and a one-cycle response pulse.
- Allows one transaction in flight at a time. Arbitration is round-robin between the two requesters.
- Sits between the core's imem/dmem interfaces and the memory macro.

Parameters:
- MEM_LATENCY, 1, cycles from the memory-enable cycle to the cycle in which mem_rdata is valid. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- if_req_valid  in  1  fetch request present.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  one-cycle pulse; if_rsp_data valid.
- if_rsp_data  out  32  fetched word.
- d_req_valid  in  1  data request present.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_we  in  4  byte write enables; 0000 = load.
- d_rsp_valid  out  1  one-cycle pulse; load data valid or store acknowledged.
- d_rsp_data  out  32  load word; 0 for stores.
- mem_en  out  1  memory access strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_we  out  4  memory byte write enables.
- mem_rdata  in  32  memory read data.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE, last_grant=DATA, wait counter=0.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_rsp_valid, d_rsp_valid, rsp data registers, busy.
  - Reset mid-transaction aborts it: no response pulse is issued and mem_en drops on the next edge.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - if_req_ready/d_req_ready are combinational and asserted only in IDLE, for the granted requester only.
  - Only IF valid: grant IF. Only D valid: grant D. Both valid: grant the requester that is not last_grant.
  - Handshake occurs when valid & ready. It latches the address, wdata, we and owner (IF forces we=0), updates last_grant, and moves to ISSUE.
  - No request: stay in IDLE; both ready signals are 0.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_addr/mem_wdata/mem_we come from the latched registers.
  - Wait counter loads MEM_LATENCY-1; next state is WAIT.
- WAIT:
  - mem_en=0 and mem_we=0. mem_addr stays held.
  - Counter decrements each cycle. When the counter is 0, capture mem_rdata (0 if the latched we!=0) into the owner's response register and go to RESP.
  - mem_rdata is therefore sampled in cycle ISSUE+MEM_LATENCY.
- RESP (1 cycle):
  - The owner's rsp_valid=1; the other requester's rsp_valid=0. Next state is IDLE.
- Latency:
  - Handshake in cycle 0, ISSUE in cycle 1, rsp_valid in cycle MEM_LATENCY+2.
  - Next accept no earlier than cycle MEM_LATENCY+3.
- Response data registers hold their values after the pulse until overwritten.
- Requester inputs are ignored outside the IDLE handshake cycle. A requester deasserting valid while not granted is legal.
- Addresses pass through unmodified; alignment is the requester's responsibility.
- Arithmetic: 4-bit wait counter with no wrap; MEM_LATENCY=1 gives a 1-cycle WAIT.

Decomposition:
- defines.vh additions:
  - Arbiter state encodings: ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP (2-bit).
  - Owner constants: GRANT_IF=0, GRANT_D=1.
- One sub-module, rr_arbiter2:
  - Combinational 2-way round-robin grant from (req_if, req_d, last_grant).
  - Outputs a one-hot grant.
- The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Single fetch, MEM_LATENCY=1: if_req_valid=1, if_addr=0x100 in cycle 0, memory returns 0x00500093 -> if_req_ready=1 in cycle 0; mem_en=1 with mem_addr=0x100 in cycle 1; if_rsp_valid=1 with data 0x00500093 in cycle 3; d_rsp_valid stays 0.
- Store: d_addr=0x2004, d_wdata=0xDEADBEEF, d_we=0011 -> ISSUE cycle has mem_we=0011, mem_wdata=0xDEADBEEF; d_rsp_valid pulses with d_rsp_data=0; mem_we=0 in all other cycles.
- Contention: both valid continuously from reset -> grant order IF, D, IF, D; each response arrives before the next accept, with no cycle where both ready signals are 1.
- MEM_LATENCY=4 load: d_we=0000, d_addr=0x40 -> rsp in cycle 6; mem_rdata is sampled in cycle 5, and the values presented in cycles 2-4 are ignored.
- Reset mid-WAIT (MEM_LATENCY=4): rst=0 in cycle 3 -> no rsp pulse ever; busy=0 and all mem outputs 0 from cycle 4; a new fetch after reset release is granted to IF.
- Backpressure: IF valid held during a D transaction -> if_req_ready=0 until IDLE, then accepted with the original address unchanged.
